// File: rtl/mfa_pkg.sv
// Shared types for the MFA sequencing front-end: controller states and
// the 2-bit nucleotide symbol encoding used on the matcher's symbol input.
package mfa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] SYM_A = 2'd0;
    localparam logic [1:0] SYM_C = 2'd1;
    localparam logic [1:0] SYM_G = 2'd2;
    localparam logic [1:0] SYM_T = 2'd3;

endpackage

// File: rtl/mfa_sym_fifo.sv
// Synchronous word FIFO with extra-bit wrap pointers; head shows the oldest
// entry whenever empty is low. A push into an empty FIFO is visible next cycle.
module mfa_sym_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: non-blocking assignments for every register, so all flops update
    // together from pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array reset-free lets it map to RAM.
    always_ff @(posedge CLK) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mfa_seq_ctrl.sv
// Sequencing front-end for the MFA matcher: buffers packed symbol words and
// streams them LSB-first, one symbol per cycle, while holding BC_mode high.
module mfa_seq_ctrl
    import mfa_pkg::*;
#(
    parameter int WORD_LEN   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_LEN    = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_LEN-1:0]  seq_len,
    input  logic [WORD_LEN-1:0] in_word,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [1:0]          symbol,
    output logic                BC_mode,
    input  logic                mfa_done,
    output logic                busy,
    output logic                finished,
    output logic                underrun,
    output logic [CNT_LEN-1:0]  sym_count
);

    localparam int SYMS = WORD_LEN / 2;
    localparam int SRCW = $clog2(SYMS);
    localparam logic [SRCW-1:0]    SR_LOAD = SRCW'(SYMS - 1);
    localparam logic [CNT_LEN-1:0] CNT_ONE = CNT_LEN'(1);

    state_e              state_q, state_d;
    logic [WORD_LEN-1:0] sr_q;
    logic [SRCW-1:0]     sr_cnt_q;
    logic [CNT_LEN-1:0]  remaining_q;
    logic [CNT_LEN-1:0]  sym_count_q;
    logic                underrun_q;
    logic [1:0]          symbol_q;
    logic                bc_q;

    logic                fifo_full, fifo_empty;
    logic [WORD_LEN-1:0] fifo_head;
    logic                push, pop;
    logic                take_start, issue, stall, flush;

    assign push = in_valid && !fifo_full;

    mfa_sym_fifo #(
        .WIDTH (WORD_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (in_word),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        take_start = 1'b0;
        issue      = 1'b0;
        pop        = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && seq_len != '0) begin
                    take_start = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else begin
                    // The shift register drains first; refill from the FIFO
                    // on the same edge it empties so words stream without gaps.
                    issue = (sr_cnt_q != '0) || !fifo_empty;
                    pop   = (sr_cnt_q == '0) && !fifo_empty;
                    stall = !issue;
                    if (issue && remaining_q == CNT_ONE)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (mfa_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                flush   = abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            sr_cnt_q    <= '0;
            remaining_q <= '0;
            sym_count_q <= '0;
            underrun_q  <= 1'b0;
            symbol_q    <= SYM_A;
            bc_q        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (take_start) begin
                remaining_q <= seq_len;
                sym_count_q <= '0;
                underrun_q  <= 1'b0;
            end

            if (issue) begin
                remaining_q <= remaining_q - 1'b1;
                sym_count_q <= sym_count_q + 1'b1;
                bc_q        <= 1'b1;
                if (pop) begin
                    symbol_q <= fifo_head[1:0];
                    sr_q     <= fifo_head >> 2;
                    sr_cnt_q <= SR_LOAD;
                end else begin
                    symbol_q <= sr_q[1:0];
                    sr_q     <= sr_q >> 2;
                    sr_cnt_q <= sr_cnt_q - 1'b1;
                end
                // Symbols left over from the final word are discarded.
                if (remaining_q == CNT_ONE)
                    sr_cnt_q <= '0;
            end else begin
                bc_q     <= 1'b0;
                symbol_q <= SYM_A;
            end

            if (stall)
                underrun_q <= 1'b1;

            if (flush) begin
                sr_q     <= '0;
                sr_cnt_q <= '0;
            end
        end
    end

    assign in_ready  = !fifo_full;
    assign symbol    = symbol_q;
    assign BC_mode   = bc_q;
    assign busy      = (state_q != IDLE);
    assign finished  = (state_q == DONE) && !abort;
    assign underrun  = underrun_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_mfa_seq_ctrl.sv
// Self-checking bench for mfa_seq_ctrl: a queue-based behavioural model is
// stepped every clock edge and compared against all DUT outputs.
module tb_mfa_seq_ctrl;

    localparam int WL = 32;
    localparam int FD = 4;
    localparam int CL = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CL-1:0] seq_len = '0;
    logic [WL-1:0] in_word = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    symbol;
    logic          BC_mode;
    logic          mfa_done = 1'b0;
    logic          busy;
    logic          finished;
    logic          underrun;
    logic [CL-1:0] sym_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mfa_seq_ctrl #(.WORD_LEN(WL), .FIFO_DEPTH(FD), .CNT_LEN(CL)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .seq_len   (seq_len),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .symbol    (symbol),
        .BC_mode   (BC_mode),
        .mfa_done  (mfa_done),
        .busy      (busy),
        .finished  (finished),
        .underrun  (underrun),
        .sym_count (sym_count)
    );

    // Behavioural model: phase 0 idle, 1 run, 2 drain, 3 done.
    int           m_phase;
    int unsigned  m_rem;
    int unsigned  m_cnt;
    bit           m_und;
    bit           m_bc;
    logic [1:0]   m_sym;
    logic [WL-1:0] m_words[$];
    logic [1:0]   m_syms[$];

    wire [22:0] dut_vec = {symbol, BC_mode, busy, finished, underrun, in_ready, sym_count};

    function automatic logic [22:0] exp_vec();
        logic       e_busy  = (m_phase != 0);
        logic       e_fin   = (m_phase == 3) && !abort;
        logic       e_ready = (m_words.size() < FD);
        logic [15:0] e_cnt  = m_cnt[15:0];
        return {m_sym, m_bc, e_busy, e_fin, m_und, e_ready, e_cnt};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_cnt = 0; m_und = 0; m_bc = 0; m_sym = 2'd0;
        m_words.delete();
        m_syms.delete();
    endtask

    task automatic model_step();
        bit push_ok = in_valid && (m_words.size() < FD);
        logic [WL-1:0] w;
        case (m_phase)
            0: begin
                m_bc = 0; m_sym = 2'd0;
                if (start && seq_len != 0) begin
                    m_phase = 1; m_rem = seq_len; m_cnt = 0; m_und = 0;
                end
            end
            1: begin
                if (abort) begin
                    m_phase = 0; m_bc = 0; m_sym = 2'd0; m_syms.delete();
                end else begin
                    if (m_syms.size() == 0 && m_words.size() != 0) begin
                        w = m_words.pop_front();
                        for (int k = 0; k < WL / 2; k++) m_syms.push_back(w[2*k +: 2]);
                    end
                    if (m_syms.size() != 0) begin
                        m_sym = m_syms.pop_front();
                        m_bc  = 1;
                        m_rem = m_rem - 1;
                        m_cnt = (m_cnt + 1) & 32'hFFFF;
                        if (m_rem == 0) begin
                            m_phase = 2;
                            m_syms.delete();
                        end
                    end else begin
                        m_sym = 2'd0; m_bc = 0; m_und = 1;
                    end
                end
            end
            2: begin
                m_bc = 0; m_sym = 2'd0;
                if (abort) m_phase = 0;
                else if (mfa_done) m_phase = 3;
            end
            default: begin
                m_bc = 0; m_sym = 2'd0; m_phase = 0;
            end
        endcase
        if (push_ok) m_words.push_back(in_word);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic push_word(input logic [WL-1:0] w);
        in_valid = 1'b1; in_word = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        mfa_done = 1'b1;
        tick();
        mfa_done = 1'b0;
        n_cmp++;
        if (finished !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL %s_finished: got finished=%b vec=%h, want finished=1 vec=%h", tag, finished, dut_vec, exp_vec());
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || finished !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL %s_idle: got busy=%b finished=%b vec=%h, want 0/0 vec=%h", tag, busy, finished, dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_values: got %h want %h", dut_vec, {2'd0, 5'b00001, 16'h0});
        end
        @(negedge CLK);
        RST = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [1:0] want;
        push_word(32'hE4E4E4E4);
        push_word(32'h1B1B1B1B);
        start = 1'b1; seq_len = 16'd20;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || BC_mode !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_start: got busy=%b bc=%b want busy=1 bc=0", busy, BC_mode);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            want = (i < 16) ? 2'(i % 4) : 2'(3 - (i - 16));
            n_cmp++;
            if (BC_mode !== 1'b1 || symbol !== want || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL basic_sym%0d: got bc=%b sym=%0d vec=%h, want bc=1 sym=%0d vec=%h",
                         i, BC_mode, symbol, dut_vec, want, exp_vec());
            end
        end
        tick();
        n_cmp++;
        if (BC_mode !== 1'b0 || sym_count !== 16'd20 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL basic_end: got bc=%b count=%0d, want bc=0 count=20", BC_mode, sym_count);
        end
        tick();
        tick();
        finish_run("basic");
    endtask

    task automatic test_underrun();
        int bc_cycles = 0;
        logic [WL-1:0] w1 = $urandom;
        logic [WL-1:0] w2 = $urandom;
        push_word(w1);
        start = 1'b1; seq_len = 16'd24;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 21) begin in_valid = 1'b1; in_word = w2; end
            tick();
            in_valid = 1'b0;
            if (BC_mode === 1'b1) bc_cycles++;
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL underrun_cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (underrun !== 1'b1 || bc_cycles != 24 || sym_count !== 16'd24) begin
            n_bad++;
            $display("FAIL underrun_totals: got und=%b bc=%0d count=%0d, want und=1 bc=24 count=24",
                     underrun, bc_cycles, sym_count);
        end
        finish_run("underrun");
    endtask

    task automatic test_fifo_full();
        logic [WL-1:0] w[4];
        logic [1:0] want;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            push_word(w[i]);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready: got in_ready=%b want 0", in_ready);
        end
        push_word(~w[0]);
        n_cmp++;
        if (in_ready !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL full_reject: got %h want %h", dut_vec, exp_vec());
        end
        start = 1'b1; seq_len = 16'd64;
        tick();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            want = w[i / 16][2 * (i % 16) +: 2];
            n_cmp++;
            if (BC_mode !== 1'b1 || symbol !== want || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL full_sym%0d: got bc=%b sym=%0d, want bc=1 sym=%0d", i, BC_mode, symbol, want);
            end
        end
        tick();
        n_cmp++;
        if (BC_mode !== 1'b0 || in_ready !== 1'b1 || sym_count !== 16'd64) begin
            n_bad++;
            $display("FAIL full_end: got bc=%b ready=%b count=%0d, want 0/1/64", BC_mode, in_ready, sym_count);
        end
        finish_run("full");
    endtask

    task automatic test_abort();
        logic [WL-1:0] w1 = $urandom;
        logic [WL-1:0] w2 = $urandom;
        push_word(w1);
        push_word(w2);
        start = 1'b1; seq_len = 16'd30;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (BC_mode !== 1'b0 || busy !== 1'b0 || finished !== 1'b0 || sym_count !== 16'd7 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL abort_state: got %h want %h (count=%0d)", dut_vec, exp_vec(), sym_count);
        end
        start = 1'b1; seq_len = 16'd16;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if (symbol !== w2[2*i +: 2] || BC_mode !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_resume%0d: got sym=%0d bc=%b want sym=%0d bc=1", i, symbol, BC_mode, w2[2*i +: 2]);
            end
        end
        tick();
        finish_run("abort");
    endtask

    task automatic test_reset_drain();
        push_word($urandom);
        push_word($urandom);
        start = 1'b1; seq_len = 16'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (busy !== 1'b1 || BC_mode !== 1'b0 || in_ready !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstdrain_pre: got %h want %h", dut_vec, exp_vec());
        end
        #2 RST = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL rstdrain_async: got %h want %h", dut_vec, {2'd0, 5'b00001, 16'h0});
        end
        @(negedge CLK);
        RST = 1'b0;
        mfa_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || finished !== 1'b0 || dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstdrain_done%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        mfa_done = 1'b0;
        // A flushed FIFO means a fresh run stalls immediately.
        start = 1'b1; seq_len = 16'd1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (BC_mode !== 1'b0 || underrun !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstdrain_flushed: got bc=%b und=%b want bc=0 und=1", BC_mode, underrun);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_zero_len();
        logic [WL-1:0] w = $urandom;
        push_word(w);
        start = 1'b1; seq_len = 16'd0;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || finished !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL zero_ignored: got %h want %h", dut_vec, exp_vec());
        end
        start = 1'b1; seq_len = 16'd16;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if (symbol !== w[2*i +: 2] || BC_mode !== 1'b1) begin
                n_bad++;
                $display("FAIL zero_untouched%0d: got sym=%0d want %0d", i, symbol, w[2*i +: 2]);
            end
        end
        tick();
        finish_run("zero");
    endtask

    task automatic test_back_to_back();
        push_word($urandom);
        start = 1'b1; seq_len = 16'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        mfa_done = 1'b1;
        tick();
        mfa_done = 1'b0;
        start = 1'b1; seq_len = 16'd5;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL b2b_done_start: got busy=%b want busy=0", busy);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL b2b_idle_start: got busy=%b want busy=1", busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_word  = $urandom;
            start    = ($urandom_range(0, 7) == 0);
            seq_len  = 16'($urandom_range(0, 40));
            abort    = ($urandom_range(0, 49) == 0);
            mfa_done = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cyc%0d: got %h want %h", c, dut_vec, exp_vec());
            end
        end
        in_valid = 1'b0; start = 1'b0; abort = 1'b1; mfa_done = 1'b0;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_fifo_full();
        test_abort();
        test_reset_drain();
        test_zero_len();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
